// File: rtl/game_pkg.sv
// Shared state codes, frame-counter width and timing defaults for the player action logic.
package game_pkg;

  localparam int FRAME_W        = 5;
  localparam int ATK_FRAMES_DEF = 6;
  localparam int DIR_FRAMES_DEF = 10;
  localparam int REC_FRAMES_DEF = 4;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_BACKWARD   = 3'd1,
    ST_FORWARD    = 3'd2,
    ST_ATTACK     = 3'd3,
    ST_DIR_ATTACK = 3'd4,
    ST_RECOVERY   = 3'd5
  } state_e;

  // Choice made from any free-moving state: dir attack beats attack beats movement.
  function automatic state_e select_next(input logic dir_press, input logic atk_press,
                                         input logic fwd, input logic bwd);
    if (dir_press)       return ST_DIR_ATTACK;
    else if (atk_press)  return ST_ATTACK;
    else if (fwd && !bwd) return ST_FORWARD;
    else if (bwd && !fwd) return ST_BACKWARD;
    else                 return ST_IDLE;
  endfunction

  function automatic logic [FRAME_W-1:0] frame_inc(input logic [FRAME_W-1:0] f);
    return (&f) ? f : f + FRAME_W'(1);
  endfunction

endpackage

// File: rtl/player_action_fsm.sv
// One player channel: press edge latches, action state machine, frame counter and position.
module player_action_fsm
  import game_pkg::*;
#(
  parameter int ATK_FRAMES = ATK_FRAMES_DEF,
  parameter int DIR_FRAMES = DIR_FRAMES_DEF,
  parameter int REC_FRAMES = REC_FRAMES_DEF,
  parameter int POS_W      = 10,
  parameter int POS_MIN    = 0,
  parameter int POS_MAX    = 560,
  parameter int STEP       = 2,
  parameter int POS_INIT   = 100
) (
  input  logic               clk_50MHz,
  input  logic               reset,
  input  logic               tick,
  input  logic               game_over,
  input  logic               i_forward,
  input  logic               i_backward,
  input  logic               i_attack,
  input  logic               i_dir_attack,
  output logic [2:0]         o_state,
  output logic [POS_W-1:0]   o_pos,
  output logic               o_hit,
  output logic [FRAME_W-1:0] o_frame
);

  localparam logic [POS_W:0]       LIM_HI   = (POS_W+1)'(POS_MAX);
  localparam logic [POS_W:0]       LIM_LO   = (POS_W+1)'(POS_MIN + STEP);
  localparam logic [FRAME_W-1:0]   ATK_LAST = FRAME_W'(ATK_FRAMES - 1);
  localparam logic [FRAME_W-1:0]   DIR_LAST = FRAME_W'(DIR_FRAMES - 1);
  localparam logic [FRAME_W-1:0]   REC_LAST = FRAME_W'(REC_FRAMES - 1);

  state_e             state_q, state_d;
  logic [POS_W-1:0]   pos_q, pos_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic               hit_q, hit_d;
  logic               atk_prev_q, dir_prev_q;
  logic               atk_lat_q, atk_lat_d, dir_lat_q, dir_lat_d;
  logic               atk_press, dir_press;
  logic [POS_W:0]     pos_up;

  always_comb begin
    // A press arriving in the tick cycle itself still counts for that tick.
    atk_press = atk_lat_q | (i_attack & ~atk_prev_q);
    dir_press = dir_lat_q | (i_dir_attack & ~dir_prev_q);
    atk_lat_d = tick ? 1'b0 : atk_press;
    dir_lat_d = tick ? 1'b0 : dir_press;
    pos_up    = {1'b0, pos_q} + (POS_W+1)'(STEP);
    state_d   = state_q;
    pos_d     = pos_q;
    frame_d   = frame_q;
    hit_d     = hit_q;
    if (tick) begin
      if (game_over) begin
        state_d = ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE, ST_BACKWARD, ST_FORWARD:
            state_d = select_next(dir_press, atk_press, i_forward, i_backward);
          ST_ATTACK:
            if (frame_q >= ATK_LAST) state_d = ST_RECOVERY;
          ST_DIR_ATTACK:
            if (frame_q >= DIR_LAST) state_d = ST_RECOVERY;
          ST_RECOVERY:
            if (frame_q >= REC_LAST) state_d = select_next(1'b0, 1'b0, i_forward, i_backward);
          default:
            state_d = ST_IDLE;
        endcase
      end
      frame_d = (state_d != state_q) ? '0 : frame_inc(frame_q);
      // Movement applies on every tick that lands in (or stays in) a moving state.
      if (state_d == ST_FORWARD) begin
        pos_d = (pos_up > LIM_HI) ? POS_W'(POS_MAX) : pos_up[POS_W-1:0];
      end else if (state_d == ST_BACKWARD) begin
        pos_d = ({1'b0, pos_q} < LIM_LO) ? POS_W'(POS_MIN) : pos_q - POS_W'(STEP);
      end
      hit_d = (state_d == ST_ATTACK) || (state_d == ST_DIR_ATTACK);
    end
  end

  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      pos_q      <= POS_W'(POS_INIT);
      frame_q    <= '0;
      hit_q      <= 1'b0;
      atk_prev_q <= 1'b0;
      dir_prev_q <= 1'b0;
      atk_lat_q  <= 1'b0;
      dir_lat_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pos_q      <= pos_d;
      frame_q    <= frame_d;
      hit_q      <= hit_d;
      atk_prev_q <= i_attack;
      dir_prev_q <= i_dir_attack;
      atk_lat_q  <= atk_lat_d;
      dir_lat_q  <= dir_lat_d;
    end
  end

  assign o_state = state_q;
  assign o_pos   = pos_q;
  assign o_hit   = hit_q;
  assign o_frame = frame_q;

endmodule

// File: rtl/player_action_ctrl.sv
// Game-tick generator plus NUM_PLAYERS independent player action channels.
module player_action_ctrl
  import game_pkg::*;
#(
  parameter int NUM_PLAYERS = 2,
  parameter int TICK_DIV    = 416_667,
  parameter int ATK_FRAMES  = ATK_FRAMES_DEF,
  parameter int DIR_FRAMES  = DIR_FRAMES_DEF,
  parameter int REC_FRAMES  = REC_FRAMES_DEF,
  parameter int POS_W       = 10,
  parameter int POS_MIN     = 0,
  parameter int POS_MAX     = 560,
  parameter int STEP        = 2,
  parameter int POS_INIT0   = 100,
  parameter int POS_INIT1   = 460
) (
  input  logic                         clk_50MHz,
  input  logic                         reset,
  input  logic                         game_over,
  input  logic [NUM_PLAYERS-1:0]       i_forward,
  input  logic [NUM_PLAYERS-1:0]       i_backward,
  input  logic [NUM_PLAYERS-1:0]       i_attack,
  input  logic [NUM_PLAYERS-1:0]       i_dir_attack,
  output logic                         o_tick,
  output logic [3*NUM_PLAYERS-1:0]     o_state,
  output logic [POS_W*NUM_PLAYERS-1:0] o_pos,
  output logic [NUM_PLAYERS-1:0]       o_hit,
  output logic [5*NUM_PLAYERS-1:0]     o_frame
);

  localparam int               CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick;

  assign tick = (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_50MHz) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign o_tick = tick;

  generate
    for (genvar gi = 0; gi < NUM_PLAYERS; gi++) begin : g_player
      localparam int INIT = (gi == 0) ? POS_INIT0 : (gi == 1) ? POS_INIT1 : POS_MIN;
      player_action_fsm #(
        .ATK_FRAMES(ATK_FRAMES),
        .DIR_FRAMES(DIR_FRAMES),
        .REC_FRAMES(REC_FRAMES),
        .POS_W     (POS_W),
        .POS_MIN   (POS_MIN),
        .POS_MAX   (POS_MAX),
        .STEP      (STEP),
        .POS_INIT  (INIT)
      ) u_fsm (
        .clk_50MHz   (clk_50MHz),
        .reset       (reset),
        .tick        (tick),
        .game_over   (game_over),
        .i_forward   (i_forward[gi]),
        .i_backward  (i_backward[gi]),
        .i_attack    (i_attack[gi]),
        .i_dir_attack(i_dir_attack[gi]),
        .o_state     (o_state[3*gi +: 3]),
        .o_pos       (o_pos[POS_W*gi +: POS_W]),
        .o_hit       (o_hit[gi]),
        .o_frame     (o_frame[FRAME_W*gi +: FRAME_W])
      );
    end
  endgenerate

endmodule

// File: tb/tb_player_action_ctrl.sv
// Directed, table-driven bench for player_action_ctrl with a 4-cycle game tick.
module tb_player_action_ctrl;

  localparam int NP = 2;
  localparam int PW = 10;

  logic            clk = 1'b0;
  logic            reset;
  logic            go;
  logic [NP-1:0]   fwd, bwd, atk, dir;
  logic            o_tick;
  logic [3*NP-1:0] o_state;
  logic [PW*NP-1:0] o_pos;
  logic [NP-1:0]   o_hit;
  logic [5*NP-1:0] o_frame;

  int checks = 0;
  int errors = 0;

  player_action_ctrl #(
    .NUM_PLAYERS(NP), .TICK_DIV(4), .ATK_FRAMES(2), .DIR_FRAMES(3), .REC_FRAMES(1),
    .POS_W(PW), .POS_MIN(0), .POS_MAX(560), .STEP(2), .POS_INIT0(100), .POS_INIT1(460)
  ) dut (
    .clk_50MHz(clk), .reset(reset), .game_over(go),
    .i_forward(fwd), .i_backward(bwd), .i_attack(atk), .i_dir_attack(dir),
    .o_tick(o_tick), .o_state(o_state), .o_pos(o_pos), .o_hit(o_hit), .o_frame(o_frame)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] fwd, bwd, atk, dir;
    logic       go;
    int         s0, s1, p0, p1;
    logic [1:0] hit;
    int         f0;
  } vec_t;

  vec_t vecs [21];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  // Wait for the tick cycle, then one more edge so the updated outputs are visible.
  task automatic step_tick();
    int n = 0;
    while (!o_tick && n < 8) begin
      @(posedge clk); #1;
      n++;
    end
    if (!o_tick) begin
      checks++;
      errors++;
      $display("FAIL tick_timeout: o_tick=0 after %0d cycles, required 1", n);
    end
    @(posedge clk); #1;
  endtask

  task automatic check_player(input string tag, input int s0, input int s1,
                              input int p0, input int p1);
    check({tag, "_s0"}, 32'(o_state[2:0]), s0);
    check({tag, "_s1"}, 32'(o_state[5:3]), s1);
    check({tag, "_p0"}, 32'(o_pos[9:0]), p0);
    check({tag, "_p1"}, 32'(o_pos[19:10]), p1);
  endtask

  task automatic check_reset_values(input string tag);
    check_player(tag, 0, 0, 100, 460);
    check({tag, "_hit"}, 32'(o_hit), 0);
    check({tag, "_frame"}, 32'(o_frame), 0);
    check({tag, "_tick"}, 32'(o_tick), 0);
  endtask

  initial begin
    //              fwd    bwd    atk    dir    go   s0 s1 p0   p1   hit    f0
    vecs[0]  = '{2'b01, 2'b00, 2'b00, 2'b00, 1'b0, 2, 0, 102, 460, 2'b00, 0};
    vecs[1]  = '{2'b01, 2'b00, 2'b00, 2'b00, 1'b0, 2, 0, 104, 460, 2'b00, 1};
    vecs[2]  = '{2'b01, 2'b00, 2'b00, 2'b00, 1'b0, 2, 0, 106, 460, 2'b00, 2};
    vecs[3]  = '{2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 0, 0, 106, 460, 2'b00, 0};
    vecs[4]  = '{2'b00, 2'b00, 2'b01, 2'b00, 1'b0, 3, 0, 106, 460, 2'b01, 0};
    vecs[5]  = '{2'b00, 2'b00, 2'b01, 2'b00, 1'b0, 3, 0, 106, 460, 2'b01, 1};
    vecs[6]  = '{2'b00, 2'b00, 2'b01, 2'b00, 1'b0, 5, 0, 106, 460, 2'b00, 0};
    vecs[7]  = '{2'b00, 2'b00, 2'b01, 2'b00, 1'b0, 0, 0, 106, 460, 2'b00, 0};
    vecs[8]  = '{2'b00, 2'b00, 2'b01, 2'b00, 1'b0, 0, 0, 106, 460, 2'b00, 1};
    vecs[9]  = '{2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 0, 0, 106, 460, 2'b00, 2};
    vecs[10] = '{2'b00, 2'b00, 2'b10, 2'b10, 1'b0, 0, 4, 106, 460, 2'b10, 3};
    vecs[11] = '{2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 0, 4, 106, 460, 2'b10, 4};
    vecs[12] = '{2'b00, 2'b00, 2'b10, 2'b00, 1'b0, 0, 4, 106, 460, 2'b10, 5};
    vecs[13] = '{2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 0, 5, 106, 460, 2'b00, 6};
    vecs[14] = '{2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 0, 0, 106, 460, 2'b00, 7};
    vecs[15] = '{2'b00, 2'b10, 2'b00, 2'b00, 1'b0, 0, 1, 106, 458, 2'b00, 8};
    vecs[16] = '{2'b11, 2'b10, 2'b00, 2'b00, 1'b0, 2, 0, 108, 458, 2'b00, 0};
    vecs[17] = '{2'b10, 2'b00, 2'b01, 2'b00, 1'b0, 3, 2, 108, 460, 2'b01, 0};
    vecs[18] = '{2'b10, 2'b00, 2'b00, 2'b00, 1'b0, 3, 2, 108, 462, 2'b01, 1};
    vecs[19] = '{2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 5, 0, 108, 462, 2'b00, 0};
    vecs[20] = '{2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 0, 0, 108, 462, 2'b00, 0};

    reset = 1'b1; go = 1'b0; fwd = '0; bwd = '0; atk = '0; dir = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");

    // First tick lands in the fourth cycle after release, then every four cycles.
    reset = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      check($sformatf("tick_pattern_c%0d", k), 32'(o_tick), 32'((k % 4) == 3));
    end

    for (int t = 0; t < 40; t++) step_tick();
    $display("idle 40 ticks: state=%0d pos=%0d/%0d frame0=%0d", o_state[2:0], o_pos[9:0], o_pos[19:10], o_frame[4:0]);
    check_player("idle", 0, 0, 100, 460);
    check("frame_sat", 32'(o_frame[4:0]), 31);

    for (int i = 0; i < 21; i++) begin
      fwd = vecs[i].fwd; bwd = vecs[i].bwd; atk = vecs[i].atk; dir = vecs[i].dir; go = vecs[i].go;
      step_tick();
      $display("vec %0d: state=%0d/%0d pos=%0d/%0d hit=%b frame0=%0d", i, o_state[2:0], o_state[5:3],
               o_pos[9:0], o_pos[19:10], o_hit, o_frame[4:0]);
      check_player($sformatf("vec%0d", i), vecs[i].s0, vecs[i].s1, vecs[i].p0, vecs[i].p1);
      check($sformatf("vec%0d_hit", i), 32'(o_hit), 32'(vecs[i].hit));
      check($sformatf("vec%0d_f0", i), 32'(o_frame[4:0]), vecs[i].f0);
    end

    // P0 walks from 108 to the right edge and saturates there.
    fwd = 2'b01; bwd = 2'b00; atk = '0; dir = '0;
    for (int t = 0; t < 225; t++) step_tick();
    $display("fwd 225 ticks: pos0=%0d", o_pos[9:0]);
    check("sat_558", 32'(o_pos[9:0]), 558);
    step_tick();
    check("sat_560", 32'(o_pos[9:0]), 560);
    step_tick();
    check("sat_hold", 32'(o_pos[9:0]), 560);
    check("sat_state", 32'(o_state[2:0]), 2);
    bwd = 2'b01;
    step_tick();
    $display("both dirs: state0=%0d pos0=%0d", o_state[2:0], o_pos[9:0]);
    check("both_idle", 32'(o_state[2:0]), 0);
    check("both_pos", 32'(o_pos[9:0]), 560);

    // P1 walks from 462 to the left edge and saturates there.
    fwd = 2'b00; bwd = 2'b10;
    for (int t = 0; t < 231; t++) step_tick();
    check("min_0", 32'(o_pos[19:10]), 0);
    step_tick();
    $display("bwd saturate: state1=%0d pos1=%0d", o_state[5:3], o_pos[19:10]);
    check("min_hold", 32'(o_pos[19:10]), 0);
    check("min_state", 32'(o_state[5:3]), 1);

    // game_over aborts an attack and freezes everything until deasserted.
    bwd = 2'b00;
    step_tick();
    atk = 2'b01;
    step_tick();
    check("go_pre_attack", 32'(o_state[2:0]), 3);
    go = 1'b1;
    step_tick();
    $display("game_over: state0=%0d hit=%b", o_state[2:0], o_hit);
    check("go_idle", 32'(o_state[2:0]), 0);
    check("go_hit", 32'(o_hit), 0);
    atk = 2'b00; bwd = 2'b01;
    step_tick();
    check("go_hold_state", 32'(o_state[2:0]), 0);
    check("go_hold_pos", 32'(o_pos[9:0]), 560);
    bwd = 2'b00; atk = 2'b01;
    step_tick();
    check("go_press_ignored", 32'(o_state[2:0]), 0);
    go = 1'b0;
    step_tick();
    $display("game_over released: state0=%0d hit=%b", o_state[2:0], o_hit);
    check("go_latch_cleared", 32'(o_state[2:0]), 0);
    check("go_release_hit", 32'(o_hit), 0);

    // Reset in the middle of an attack.
    atk = 2'b00;
    step_tick();
    atk = 2'b01;
    step_tick();
    check("rst_pre_attack", 32'(o_state[2:0]), 3);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    $display("reset mid-attack: state=%0d pos=%0d/%0d hit=%b", o_state[2:0], o_pos[9:0], o_pos[19:10], o_hit);
    check_reset_values("rst_mid");
    atk = 2'b00;
    reset = 1'b0;
    step_tick();
    check_player("post_rst", 0, 0, 100, 460);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
